covariance_accumulator: RTL and testbench
=========================================

Name: covariance_accumulator

Overview:
- Stage directly downstream of the centering unit in the whitening path.
- Once centering has written 128 zero-mean sample pairs (x, y) to the sample RAM, this block reads them back in order.
- Accumulates x*x, x*y and y*y, then divides by N with an arithmetic shift.
- Presents the 2x2 covariance matrix entries to the eigen/whitening-matrix stage, with a busy/done handshake.

Parameters:
N_SAMPLES, 128, number of sample pairs per run (power of two)
LOG2_N, 7, log2(N_SAMPLES); address width and divide shift
DW, 16, width of each signed centered sample
ACC_W, 39, accumulator width, 2*DW+LOG2_N (cannot overflow)

Ports:
CLK_cov  in  1  single clock, rising edge
RST_cov  in  1  asynchronous, active-high reset
GO_cov  in  1  start request; a run begins on a sampled 0->1 edge
RAM_Addr  out  LOG2_N  sample RAM read address
RAM_Rd  out  1  sample RAM read enable
Din_x  in  DW  signed centered x; valid the cycle after RAM_Rd/RAM_Addr
Din_y  in  DW  signed centered y; same timing as Din_x
COV_Busy  out  1  high while a run is in progress
COV_Done  out  1  one-cycle pulse when outputs update
Cov_xx  out  2*DW  signed E[x*x]
Cov_xy  out  2*DW  signed E[x*y]
Cov_yy  out  2*DW  signed E[y*y]

Behaviour:
- Reset (RST_cov=1, async) forces the following, including mid-run (a partial run is discarded, no Done):
  - state=IDLE; RAM_Addr=0; RAM_Rd=0.
  - COV_Busy=0; COV_Done=0; Cov_*=0.
  - accumulators=0; GO edge register=0.
- Start detect:
  - go_d is GO_cov registered.
  - Start = GO_cov & ~go_d, acted on only in IDLE.
  - A GO edge while busy is ignored and is not queued.
  - GO held high does not retrigger.
- FSM:
  - IDLE: on start edge E0, clear all three accumulators, set RAM_Rd=1, RAM_Addr=0, COV_Busy=1, go to READ.
  - READ: each edge, if RAM_Addr==N_SAMPLES-1, set RAM_Rd=0 and go to DRAIN; otherwise RAM_Addr+1. Addresses 0..N-1 are issued on consecutive cycles with no gaps.
  - DRAIN: one cycle; the last sample is accumulated at this edge. Go to SCALE.
  - SCALE: register Cov_* = accumulator >>> LOG2_N, keeping the low 2*DW bits. Set COV_Done=1 for one cycle, COV_Busy=0, RAM_Addr=0, go to IDLE.
- Accumulate pipeline:
  - rd_d1 is RAM_Rd registered.
  - On each edge with rd_d1=1, add the full-precision signed products Din_x*Din_x, Din_x*Din_y and Din_y*Din_y, sign-extended to ACC_W, into the three accumulators.
  - Exactly N_SAMPLES products are accumulated per run.
- Timing (N=128):
  - Busy rises at E0 and falls at E0+N+2.
  - COV_Done is high for exactly the cycle after edge E0+N+2.
  - Run length from start edge to Done is 130 cycles. A new start edge is accepted from the Done cycle onward.
- Arithmetic:
  - Division is an arithmetic right shift, so it rounds toward negative infinity.
  - The mean of DW x DW products always fits in 2*DW signed bits; no saturation.
  - -2^(DW-1) squared = 2^(2*DW-2) is representable.
- Outputs: Cov_* hold their value between runs. They change only in SCALE or on reset.

Test Plan:
- Constant data: x=+1, y=-1 at all 128 addresses, pulse GO -> Cov_xx=1, Cov_xy=-1, Cov_yy=1.
- Alternating data: x alternating +2/-2, y=+3 -> Cov_xx=4, Cov_xy=0, Cov_yy=9.
- Handshake timing: check the following against start edge E0.
  - Done goes high exactly 130 cycles after E0 and lasts 1 cycle.
  - Busy is high for 130 cycles.
  - RAM_Rd is high for 128 consecutive cycles with addresses 0..127 in order.
- Rounding: only addr 5 nonzero, x=1, y=-1 -> Cov_xx=0, Cov_xy=-1, Cov_yy=0.
- Extreme values: x=y=-32768 everywhere -> Cov_xx=Cov_xy=Cov_yy=1073741824, with no wrap.
- Control robustness:
  - Second GO edge mid-run -> ignored, with a single Done.
  - GO held high across Done -> no rerun.
  - RST_cov asserted at address 60 -> outputs 0, no Done; a fresh GO afterwards gives correct results.

Source files
------------

// File: rtl/covariance_accumulator.sv
// Covariance accumulator: reads N centered (x, y) sample pairs from the sample
// RAM in address order, accumulates x*x, x*y and y*y at full precision, then
// divides by N with an arithmetic shift and presents the 2x2 covariance terms
// with a busy/done handshake.
module covariance_accumulator #(
  parameter int N_SAMPLES = 128,
  parameter int LOG2_N    = 7,
  parameter int DW        = 16,
  parameter int ACC_W     = 2*DW + LOG2_N
) (
  input  logic              CLK_cov,
  input  logic              RST_cov,
  input  logic              GO_cov,
  output logic [LOG2_N-1:0] RAM_Addr,
  output logic              RAM_Rd,
  input  logic [DW-1:0]     Din_x,
  input  logic [DW-1:0]     Din_y,
  output logic              COV_Busy,
  output logic              COV_Done,
  output logic [2*DW-1:0]   Cov_xx,
  output logic [2*DW-1:0]   Cov_xy,
  output logic [2*DW-1:0]   Cov_yy
);

  localparam logic [LOG2_N-1:0] LAST_ADDR = LOG2_N'(N_SAMPLES - 1);
  localparam logic [LOG2_N-1:0] ADDR_ONE  = LOG2_N'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_SCALE
  } state_t;

  state_t state_q, state_d;

  logic              go_q;
  logic              start;
  logic              rd_q, rd_d;
  logic              rd_d1_q;
  logic [LOG2_N-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic signed [ACC_W-1:0] acc_xx_q, acc_xx_d;
  logic signed [ACC_W-1:0] acc_xy_q, acc_xy_d;
  logic signed [ACC_W-1:0] acc_yy_q, acc_yy_d;

  logic [2*DW-1:0] cov_xx_q, cov_xx_d;
  logic [2*DW-1:0] cov_xy_q, cov_xy_d;
  logic [2*DW-1:0] cov_yy_q, cov_yy_d;

  logic signed [2*DW-1:0]  x_ext, y_ext;
  logic signed [2*DW-1:0]  prod_xx, prod_xy, prod_yy;
  logic signed [ACC_W-1:0] prod_xx_ext, prod_xy_ext, prod_yy_ext;
  logic signed [ACC_W-1:0] mean_xx, mean_xy, mean_yy;

  // Rising edge of GO; only acted on while idle.
  assign start = GO_cov & ~go_q;

  // Full-precision signed products; operands are widened first so the
  // product of two DW-bit values is formed in 2*DW bits without truncation.
  always_comb begin
    x_ext       = {{DW{Din_x[DW-1]}}, Din_x};
    y_ext       = {{DW{Din_y[DW-1]}}, Din_y};
    prod_xx     = x_ext * x_ext;
    prod_xy     = x_ext * y_ext;
    prod_yy     = y_ext * y_ext;
    prod_xx_ext = {{(ACC_W-2*DW){prod_xx[2*DW-1]}}, prod_xx};
    prod_xy_ext = {{(ACC_W-2*DW){prod_xy[2*DW-1]}}, prod_xy};
    prod_yy_ext = {{(ACC_W-2*DW){prod_yy[2*DW-1]}}, prod_yy};
    mean_xx     = acc_xx_q >>> LOG2_N;
    mean_xy     = acc_xy_q >>> LOG2_N;
    mean_yy     = acc_yy_q >>> LOG2_N;
  end

  // Sequencer: next state, read address/enable, busy/done and result capture.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cov_xx_d = cov_xx_q;
    cov_xy_d = cov_xy_q;
    cov_yy_d = cov_yy_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_d    = 1'b1;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) begin
          rd_d    = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_SCALE;
      end
      S_SCALE: begin
        cov_xx_d = mean_xx[2*DW-1:0];
        cov_xy_d = mean_xy[2*DW-1:0];
        cov_yy_d = mean_yy[2*DW-1:0];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        addr_d   = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Accumulators: cleared on an accepted start, otherwise summed one cycle
  // after each read because RAM data arrives a cycle after the address.
  always_comb begin
    acc_xx_d = acc_xx_q;
    acc_xy_d = acc_xy_q;
    acc_yy_d = acc_yy_q;
    if (state_q == S_IDLE && start) begin
      acc_xx_d = '0;
      acc_xy_d = '0;
      acc_yy_d = '0;
    end else if (rd_d1_q) begin
      acc_xx_d = acc_xx_q + prod_xx_ext;
      acc_xy_d = acc_xy_q + prod_xy_ext;
      acc_yy_d = acc_yy_q + prod_yy_ext;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK_cov or posedge RST_cov) begin
    if (RST_cov) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_d1_q  <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_xx_q <= '0;
      acc_xy_q <= '0;
      acc_yy_q <= '0;
      cov_xx_q <= '0;
      cov_xy_q <= '0;
      cov_yy_q <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= GO_cov;
      rd_q     <= rd_d;
      rd_d1_q  <= rd_q;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_xx_q <= acc_xx_d;
      acc_xy_q <= acc_xy_d;
      acc_yy_q <= acc_yy_d;
      cov_xx_q <= cov_xx_d;
      cov_xy_q <= cov_xy_d;
      cov_yy_q <= cov_yy_d;
    end
  end

  assign RAM_Addr = addr_q;
  assign RAM_Rd   = rd_q;
  assign COV_Busy = busy_q;
  assign COV_Done = done_q;
  assign Cov_xx   = cov_xx_q;
  assign Cov_xy   = cov_xy_q;
  assign Cov_yy   = cov_yy_q;

endmodule

// File: tb/tb_covariance_accumulator.sv
// Bench for covariance_accumulator: sample RAM model, run-level reference
// model checked every cycle, plus directed scenarios with literal results.
module tb_covariance_accumulator;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go  = 1'b0;
  logic [6:0]  addr;
  logic        rd;
  logic [15:0] din_x = '0;
  logic [15:0] din_y = '0;
  logic        busy, done;
  logic [31:0] cxx, cxy, cyy;

  logic signed [15:0] mem_x [N];
  logic signed [15:0] mem_y [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  covariance_accumulator #(
    .N_SAMPLES(128),
    .LOG2_N   (7),
    .DW       (16),
    .ACC_W    (39)
  ) dut (
    .CLK_cov (clk),
    .RST_cov (rst),
    .GO_cov  (go),
    .RAM_Addr(addr),
    .RAM_Rd  (rd),
    .Din_x   (din_x),
    .Din_y   (din_y),
    .COV_Busy(busy),
    .COV_Done(done),
    .Cov_xx  (cxx),
    .Cov_xy  (cxy),
    .Cov_yy  (cyy)
  );

  // Synchronous-read sample RAM: data valid the cycle after the read.
  always @(posedge clk) begin
    if (rd) begin
      din_x <= mem_x[addr];
      din_y <= mem_y[addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mean of products over the whole RAM, floor-divided by N.
  function automatic logic [31:0] mean_prod(input int sel);
    longint s;
    longint a, b, q;
    s = 0;
    for (int i = 0; i < N; i++) begin
      a = (sel == 2) ? longint'(mem_y[i]) : longint'(mem_x[i]);
      b = (sel == 0) ? longint'(mem_x[i]) : longint'(mem_y[i]);
      s += a * b;
    end
    q = s >>> 7;
    return q[31:0];
  endfunction

  // Reference model: a run lasts 130 edges after the accepted start edge.
  bit          m_run = 0;
  int          m_t = 0;
  bit          m_go_prev = 0;
  bit          e_done = 0;
  logic [31:0] e_xx = '0, e_xy = '0, e_yy = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_t = 0; m_go_prev = 0; e_done = 0;
      e_xx = '0; e_xy = '0; e_yy = '0;
    end else begin
      e_done = 0;
      if (m_run) begin
        m_t++;
        if (m_t == 130) begin
          m_run = 0;
          e_done = 1;
          e_xx = mean_prod(0);
          e_xy = mean_prod(1);
          e_yy = mean_prod(2);
        end
      end else if (go && !m_go_prev) begin
        m_run = 1;
        m_t = 0;
      end
      m_go_prev = go;
    end
  end

  bit chk_en = 0;
  int cyc = 0;
  int busy_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0;

  // Per-cycle compare against the model, plus run statistics.
  always @(negedge clk) begin
    int ea;
    cyc++;
    if (busy) busy_cnt++;
    if (rd) rd_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (chk_en) begin
      ea = (m_run && m_t <= 127) ? m_t : (m_run ? 127 : 0);
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(e_done));
      chk("ram_rd", 32'(rd), 32'(m_run && m_t <= 127));
      chk("ram_addr", 32'(addr), 32'(ea));
      chk("cov_xx", cxx, e_xx);
      chk("cov_xy", cxy, e_xy);
      chk("cov_yy", cyy, e_yy);
    end
  end

  int g_cyc;

  task automatic pulse_go();
    @(negedge clk); #1;
    go = 1'b1;
    g_cyc = cyc;
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s: got no done expected done within 300 cycles", nm);
    end
  endtask

  task automatic chk_cov(input string nm, input int xx, input int xy, input int yy);
    chk({nm, "_xx"}, cxx, xx);
    chk({nm, "_xy"}, cxy, xy);
    chk({nm, "_yy"}, cyy, yy);
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: begin mem_x[i] = 16'sd1; mem_y[i] = -16'sd1; end
        1: begin mem_x[i] = (i % 2 == 0) ? 16'sd2 : -16'sd2; mem_y[i] = 16'sd3; end
        2: begin mem_x[i] = (i == 5) ? 16'sd1 : 16'sd0; mem_y[i] = (i == 5) ? -16'sd1 : 16'sd0; end
        default: begin mem_x[i] = 16'sh8000; mem_y[i] = 16'sh8000; end
      endcase
    end
  endtask

  initial begin
    bit hit;
    fill(0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rd", 32'(rd), 0);
    chk("reset_addr", 32'(addr), 0);
    chk_cov("reset", 0, 0, 0);
    rst = 1'b0;
    chk_en = 1;

    // Constant data with handshake timing.
    @(negedge clk); #1;
    busy_cnt = 0; rd_cnt = 0; done_cnt = 0;
    go = 1'b1;
    g_cyc = cyc;
    @(negedge clk); #1;
    go = 1'b0;
    wait_done("const_done");
    repeat (4) @(negedge clk);
    #1;
    chk("done_latency", done_cyc - g_cyc, 131);
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cnt, 130);
    chk("rd_cycles", rd_cnt, 128);
    chk_cov("const", 1, -1, 1);

    // Alternating x, constant y.
    fill(1);
    pulse_go();
    wait_done("alt_done");
    @(negedge clk); #1;
    chk_cov("alt", 4, 0, 9);

    // Single nonzero sample: floor division toward minus infinity.
    fill(2);
    pulse_go();
    wait_done("round_done");
    @(negedge clk); #1;
    chk_cov("round", 0, -1, 0);

    // Most negative samples everywhere.
    fill(3);
    pulse_go();
    wait_done("extreme_done");
    @(negedge clk); #1;
    chk_cov("extreme", 1073741824, 1073741824, 1073741824);

    // Second GO edge mid-run is ignored.
    fill(1);
    done_cnt = 0;
    pulse_go();
    repeat (50) @(negedge clk);
    pulse_go();
    repeat (250) @(negedge clk);
    #1;
    chk("midgo_done_count", done_cnt, 1);
    chk_cov("midgo", 4, 0, 9);

    // GO held high across Done does not rerun.
    fill(0);
    @(negedge clk); #1;
    done_cnt = 0;
    go = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    go = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("held_done_count", done_cnt, 1);
    chk_cov("held", 1, -1, 1);

    // Reset at address 60 discards the run.
    fill(1);
    pulse_go();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (rd && addr == 7'd60) hit = 1;
    end
    chk("reach_addr60", 32'(hit), 1);
    rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(rd), 0);
    chk_cov("rst", 0, 0, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    repeat (200) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt, 0);
    chk_cov("rst_hold", 0, 0, 0);

    fill(3);
    pulse_go();
    wait_done("after_rst_done");
    @(negedge clk); #1;
    chk_cov("after_rst", 1073741824, 1073741824, 1073741824);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
